// File: rtl/ceespu_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings, the NOP word and the
// synthetic interrupt-branch instruction builder.
package ceespu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_S_RESET = 2'd0,
    FETCH_S_RUN   = 2'd1,
    FETCH_S_IRQ   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] CEESPU_NOP       = 32'h0000_0000;
  localparam logic [5:0]  CEESPU_OPC_BR    = 6'b110000;
  localparam logic [4:0]  CEESPU_IRQ_LINK  = 5'd17;
  localparam logic [2:0]  CEESPU_COND_ALWS = 3'b000;

  // BRANCH always with link into r17; word target in the low 14 bits.
  function automatic logic [31:0] ceespu_irq_insn(input logic [13:0] target);
    return {CEESPU_OPC_BR, CEESPU_IRQ_LINK, CEESPU_COND_ALWS, 1'b1, 3'b000, target};
  endfunction

endpackage

// File: rtl/ceespu_pc_next.sv
// Next-PC priority mux and instruction-memory read enable for the fetch stage.
module ceespu_pc_next #(
  parameter logic [13:0] RESET_PC   = 14'h0000,
  parameter logic [13:0] IRQ_VECTOR = 14'h0004
) (
  input  logic        in_reset,
  input  logic [13:0] pc_q,
  input  logic        branch,
  input  logic [13:0] branch_target,
  input  logic        irq_take,
  input  logic        stall,
  output logic [13:0] pc_next,
  output logic        imem_en
);

  // Redirects beat stalls so a resolved branch is never lost while decode holds.
  always_comb begin
    pc_next = pc_q + 14'd1;
    imem_en = 1'b1;
    if (in_reset) begin
      pc_next = RESET_PC;
    end else if (branch) begin
      pc_next = branch_target;
    end else if (irq_take) begin
      pc_next = IRQ_VECTOR;
    end else if (stall) begin
      pc_next = pc_q;
      imem_en = 1'b0;
    end else begin
      pc_next = pc_q + 14'd1;
    end
  end

endmodule

// File: rtl/ceespu_fetch.sv
// ceespu instruction-fetch stage. Interrupt injection is built only when
// CEESPU_FETCH_IRQ_EN is defined; otherwise I_irq/I_interrupts_enabled are ignored.
module ceespu_fetch
  import ceespu_fetch_pkg::*;
#(
  parameter logic [13:0] RESET_PC   = 14'h0000,
  parameter logic [13:0] IRQ_VECTOR = 14'h0004
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_stall,
  input  logic        I_branch,
  input  logic [13:0] I_branchTarget,
  input  logic        I_irq,
  input  logic        I_interrupts_enabled,
  output logic [13:0] O_imem_addr,
  output logic        O_imem_en,
  input  logic [31:0] I_imem_data,
  output logic [31:0] O_instruction,
  output logic [13:0] O_PC,
  output logic        O_did_interrupt
);

  fetch_state_e state_q, state_d;
  logic [13:0]  pc_q, pc_d;
  logic [13:0]  pc_next;
  logic         imem_en;
  logic         irq_take;
  logic         irq_exit;

`ifdef CEESPU_FETCH_IRQ_EN
  assign irq_take = (state_q == FETCH_S_RUN) & I_irq & I_interrupts_enabled
                    & ~I_branch & ~I_stall;
  // Handler mode ends when software masks interrupts or the handler branches away.
  assign irq_exit = I_branch | (~I_stall & ~I_interrupts_enabled);
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = I_irq ^ I_interrupts_enabled;
  assign irq_take = 1'b0;
  assign irq_exit = 1'b1;
`endif

  ceespu_pc_next #(
    .RESET_PC   (RESET_PC),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_pc_next (
    .in_reset      (state_q == FETCH_S_RESET),
    .pc_q          (pc_q),
    .branch        (I_branch),
    .branch_target (I_branchTarget),
    .irq_take      (irq_take),
    .stall         (I_stall),
    .pc_next       (pc_next),
    .imem_en       (imem_en)
  );

  assign O_imem_addr = pc_next;
  assign O_imem_en   = imem_en;

  // pc_q tracks the address whose data the memory is currently presenting.
  always_comb begin
    state_d = state_q;
    if (imem_en) begin
      pc_d = pc_next;
    end else begin
      pc_d = pc_q;
    end
    case (state_q)
      FETCH_S_RESET: state_d = FETCH_S_RUN;
      FETCH_S_RUN: begin
        if (irq_take) begin
          state_d = FETCH_S_IRQ;
        end else begin
          state_d = FETCH_S_RUN;
        end
      end
      FETCH_S_IRQ: begin
        if (irq_exit) begin
          state_d = FETCH_S_RUN;
        end else begin
          state_d = FETCH_S_IRQ;
        end
      end
      default: state_d = FETCH_S_RESET;
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= FETCH_S_RESET;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Squash slots become NOP; an irq take replaces the slot with a linking branch
  // whose PC is one behind so the return lands on the replaced instruction.
  always_comb begin
    O_instruction   = I_imem_data;
    O_PC            = pc_q;
    O_did_interrupt = 1'b0;
    if ((state_q == FETCH_S_RESET) || I_branch) begin
      O_instruction = CEESPU_NOP;
    end else if (irq_take) begin
      O_instruction   = ceespu_irq_insn(IRQ_VECTOR);
      O_PC            = pc_q - 14'd1;
      O_did_interrupt = 1'b1;
    end else begin
      O_instruction = I_imem_data;
    end
  end

endmodule

// File: tb/tb_ceespu_fetch.sv
// Directed bench for ceespu_fetch; two instances (RESET_PC 0 and 3FFE) each
// with a 1-cycle synchronous memory model.
module tb_ceespu_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch, irq, ie;
  logic [13:0] target;
  logic [13:0] a_addr, a_pc, b_addr, b_pc;
  logic        a_en, a_did, b_en, b_did;
  logic [31:0] a_data, a_insn, b_data, b_insn;
  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] IRQ_INSN = 32'hC222_0004;

  function automatic logic [31:0] mem_fn(input logic [13:0] a);
    if (a == 14'h0000) return 32'h1234_5678;
    return {16'hC0DE, 2'b00, a};
  endfunction

  always @(posedge clk) begin
    if (a_en) a_data <= mem_fn(a_addr);
  end

  always @(posedge clk) begin
    if (b_en) b_data <= mem_fn(b_addr);
  end

  ceespu_fetch dut_a (
    .I_clk(clk), .I_rst(rst), .I_stall(stall), .I_branch(branch),
    .I_branchTarget(target), .I_irq(irq), .I_interrupts_enabled(ie),
    .O_imem_addr(a_addr), .O_imem_en(a_en), .I_imem_data(a_data),
    .O_instruction(a_insn), .O_PC(a_pc), .O_did_interrupt(a_did)
  );

  ceespu_fetch #(.RESET_PC(14'h3FFE)) dut_b (
    .I_clk(clk), .I_rst(rst), .I_stall(1'b0), .I_branch(1'b0),
    .I_branchTarget(14'h0000), .I_irq(1'b0), .I_interrupts_enabled(1'b0),
    .O_imem_addr(b_addr), .O_imem_en(b_en), .I_imem_data(b_data),
    .O_instruction(b_insn), .O_PC(b_pc), .O_did_interrupt(b_did)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_a(input string tag, input logic [31:0] insn, input logic [13:0] pc,
                          input logic [13:0] addr, input logic en, input logic did);
    chk({tag, ".insn"}, a_insn, insn);
    chk({tag, ".pc"}, {18'd0, a_pc}, {18'd0, pc});
    chk({tag, ".addr"}, {18'd0, a_addr}, {18'd0, addr});
    chk({tag, ".en"}, {31'd0, a_en}, {31'd0, en});
    chk({tag, ".did"}, {31'd0, a_did}, {31'd0, did});
  endtask

  task automatic expect_b(input string tag, input logic [31:0] insn, input logic [13:0] pc,
                          input logic [13:0] addr);
    chk({tag, ".b_insn"}, b_insn, insn);
    chk({tag, ".b_pc"}, {18'd0, b_pc}, {18'd0, pc});
    chk({tag, ".b_addr"}, {18'd0, b_addr}, {18'd0, addr});
    chk({tag, ".b_did"}, {31'd0, b_did}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; irq = 1'b0; ie = 1'b0; target = 14'h0000;
    step(); step(); settle();
    expect_a("in_reset", NOP, 14'h0000, 14'h0000, 1'b1, 1'b0);
    expect_b("in_reset", NOP, 14'h3FFE, 14'h3FFE);

    step(); rst = 1'b0; settle();
    expect_a("cyc0", NOP, 14'h0000, 14'h0000, 1'b1, 1'b0);
    expect_b("cyc0", NOP, 14'h3FFE, 14'h3FFE);
    step(); settle();
    expect_a("cyc1", 32'h1234_5678, 14'h0000, 14'h0001, 1'b1, 1'b0);
    expect_b("wrap0", mem_fn(14'h3FFE), 14'h3FFE, 14'h3FFF);
    step(); settle();
    expect_a("cyc2", mem_fn(14'h0001), 14'h0001, 14'h0002, 1'b1, 1'b0);
    expect_b("wrap1", mem_fn(14'h3FFF), 14'h3FFF, 14'h0000);
    step(); settle();
    expect_b("wrap2", 32'h1234_5678, 14'h0000, 14'h0001);
    for (int i = 3; i <= 5; i++) begin
      step(); settle();
      chk("seq.pc", {18'd0, a_pc}, i);
    end

    branch = 1'b1; target = 14'h0020; settle();
    expect_a("br_squash", NOP, 14'h0005, 14'h0020, 1'b1, 1'b0);
    step(); branch = 1'b0; settle();
    expect_a("br_target", mem_fn(14'h0020), 14'h0020, 14'h0021, 1'b1, 1'b0);
    step(); settle();
    expect_a("br_next", mem_fn(14'h0021), 14'h0021, 14'h0022, 1'b1, 1'b0);

    branch = 1'b1; target = 14'h0007; settle();
    step(); branch = 1'b0; stall = 1'b1; settle();
    expect_a("stall0", mem_fn(14'h0007), 14'h0007, 14'h0007, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      step(); settle();
      expect_a("stall_hold", mem_fn(14'h0007), 14'h0007, 14'h0007, 1'b0, 1'b0);
    end
    step(); stall = 1'b0; settle();
    expect_a("stall_rel", mem_fn(14'h0007), 14'h0007, 14'h0008, 1'b1, 1'b0);
    step(); settle();
    expect_a("stall_after", mem_fn(14'h0008), 14'h0008, 14'h0009, 1'b1, 1'b0);

    stall = 1'b1; branch = 1'b1; target = 14'h0030; settle();
    expect_a("br_in_stall", NOP, 14'h0008, 14'h0030, 1'b1, 1'b0);
    step(); stall = 1'b0; branch = 1'b0; settle();
    expect_a("br_in_stall_tgt", mem_fn(14'h0030), 14'h0030, 14'h0031, 1'b1, 1'b0);

    branch = 1'b1; target = 14'h0009; settle();
    step(); branch = 1'b0; settle();
    chk("at9.pc", {18'd0, a_pc}, 32'd9);

`ifdef CEESPU_FETCH_IRQ_EN
    irq = 1'b1; ie = 1'b1; stall = 1'b1; settle();
    expect_a("irq_stalled", mem_fn(14'h0009), 14'h0009, 14'h0009, 1'b0, 1'b0);
    stall = 1'b0; settle();
    expect_a("irq_take", IRQ_INSN, 14'h0008, 14'h0004, 1'b1, 1'b1);
    step(); settle();
    expect_a("irq_vec", mem_fn(14'h0004), 14'h0004, 14'h0005, 1'b1, 1'b0);
    step(); settle();
    expect_a("irq_noretake", mem_fn(14'h0005), 14'h0005, 14'h0006, 1'b1, 1'b0);
    ie = 1'b0; settle();
    step(); ie = 1'b1; settle();
    expect_a("irq_retake", IRQ_INSN, 14'h0005, 14'h0004, 1'b1, 1'b1);
    step(); ie = 1'b0; settle();
    chk("irq_vec2.pc", {18'd0, a_pc}, 32'd4);
    step(); ie = 1'b1; branch = 1'b1; target = 14'h0040; settle();
    expect_a("irq_vs_br", NOP, 14'h0005, 14'h0040, 1'b1, 1'b0);
    step(); branch = 1'b0; settle();
    expect_a("irq_after_br", IRQ_INSN, 14'h003F, 14'h0004, 1'b1, 1'b1);
    step(); settle();
    expect_a("irq_vec3", mem_fn(14'h0004), 14'h0004, 14'h0005, 1'b1, 1'b0);
`else
    irq = 1'b1; ie = 1'b1; settle();
    expect_a("irq_off", mem_fn(14'h0009), 14'h0009, 14'h000A, 1'b1, 1'b0);
    step(); settle();
    expect_a("irq_off_next", mem_fn(14'h000A), 14'h000A, 14'h000B, 1'b1, 1'b0);
    branch = 1'b1; target = 14'h0040; settle();
    expect_a("irq_off_br", NOP, 14'h000A, 14'h0040, 1'b1, 1'b0);
    step(); branch = 1'b0; settle();
    expect_a("irq_off_tgt", mem_fn(14'h0040), 14'h0040, 14'h0041, 1'b1, 1'b0);
`endif

    rst = 1'b1; irq = 1'b0; step(); settle();
    expect_a("mid_reset", NOP, 14'h0000, 14'h0000, 1'b1, 1'b0);
    rst = 1'b0; step(); settle();
    expect_a("mid_reset_rel", 32'h1234_5678, 14'h0000, 14'h0001, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
